// File: rtl/poly_mul_schb_param_if.sv
// rtl/poly_mul_schb_param_if.sv - memory bus between the multiplier and its RAM
// One read port with 1-cycle latency and one write port.
interface poly_mul_schb_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr;
  logic              write;
  logic [DATA_W-1:0] data_out;

  modport master (input data_in, output r_addr, w_addr, write, data_out);
  modport slave  (output data_in, input r_addr, w_addr, write, data_out);
endinterface

// File: rtl/poly_mul_schb_param.sv
// rtl/poly_mul_schb_param.sv - schoolbook polynomial multiply, small signed secret times public poly
// One public coefficient per COMPUTE step is broadcast across N lanes against a rotating secret.
module poly_mul_schb_param #(
  parameter int N           = 256,
  parameter int COEFF_WIDTH = 16,
  parameter int DATA_W      = 16,
  parameter int S_BITS      = 2,
  parameter int ADDR_W      = 10,
  parameter int A_BASE      = 0,
  parameter int S_BASE      = 256,
  parameter int R_BASE      = 512
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic acc,
  input  logic negacyc,
  input  logic wb,
  output logic busy,
  output logic done,
  poly_mul_schb_param_if.master mem
);
  localparam int S_WORDS = N * S_BITS / DATA_W;
  localparam int SV_W    = N * S_BITS;
  localparam int CNT_W   = $clog2(N) + 2;

  typedef enum logic [1:0] {IDLE, LOAD_S, COMPUTE, WRITE_BACK} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   negacyc_q, negacyc_d;
  logic [COEFF_WIDTH-1:0] a_q, a_d;
  logic [SV_W-1:0]        s_q, s_d;
  logic [COEFF_WIDTH-1:0] res_q [N];
  logic [COEFF_WIDTH-1:0] res_d [N];
  logic [COEFF_WIDTH-1:0] prod  [N];
  logic                   last_s, last_c, last_w;

  assign last_s = (cnt_q == CNT_W'(S_WORDS));
  assign last_c = (cnt_q == CNT_W'(N + 1));
  assign last_w = (cnt_q == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      negacyc_q <= 1'b0;
      a_q       <= '0;
      s_q       <= '0;
      for (int i = 0; i < N; i++) res_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      negacyc_q <= negacyc_d;
      a_q       <= a_d;
      s_q       <= s_d;
      for (int i = 0; i < N; i++) res_q[i] <= res_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start)   state_d = LOAD_S;
        else if (wb) state_d = WRITE_BACK;
      end
      LOAD_S: if (last_s) begin
        state_d = COMPUTE;
        cnt_d   = '0;
      end
      COMPUTE: if (last_c) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      WRITE_BACK: if (last_w) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Magnitude-only product; the sign bit selects add or subtract, so -0 contributes nothing.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      prod[i] = a_q * COEFF_WIDTH'(s_q[i*S_BITS +: S_BITS-1]);
    end
  end

  always_comb begin
    negacyc_d = negacyc_q;
    a_d       = a_q;
    s_d       = s_q;
    res_d     = res_q;
    case (state_q)
      IDLE: if (start) begin
        negacyc_d = negacyc;
        if (!acc) for (int i = 0; i < N; i++) res_d[i] = '0;
      end
      LOAD_S: if (cnt_q != '0) begin
        s_d = SV_W'({mem.data_in, s_q} >> DATA_W);
      end
      COMPUTE: begin
        a_d = mem.data_in[COEFF_WIDTH-1:0];
        // a_q holds a_(cnt-2); the secret has already rotated cnt-2 times
        if (cnt_q >= CNT_W'(2)) begin
          for (int i = 0; i < N; i++) begin
            res_d[i] = s_q[i*S_BITS + S_BITS - 1] ? res_q[i] - prod[i] : res_q[i] + prod[i];
          end
          s_d = {s_q[SV_W-S_BITS-1:0],
                 s_q[SV_W-1 -: S_BITS] ^ {negacyc_q, {(S_BITS-1){1'b0}}}};
        end
      end
      WRITE_BACK: begin
        for (int i = 0; i < N; i++) res_d[i] = res_q[(i + 1) % N];
      end
      default: ;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    mem.write    = 1'b0;
    mem.r_addr   = '0;
    mem.w_addr   = '0;
    mem.data_out = '0;
    if (resetn) begin
      busy = (state_q != IDLE);
      case (state_q)
        LOAD_S: if (cnt_q < CNT_W'(S_WORDS)) begin
          mem.r_addr = ADDR_W'(S_BASE) + ADDR_W'(cnt_q);
        end
        COMPUTE: begin
          if (cnt_q < CNT_W'(N)) mem.r_addr = ADDR_W'(A_BASE) + ADDR_W'(cnt_q);
          done = last_c;
        end
        WRITE_BACK: begin
          mem.write    = 1'b1;
          mem.w_addr   = ADDR_W'(R_BASE) + ADDR_W'(cnt_q);
          mem.data_out = DATA_W'(res_q[0]);
          done         = last_w;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/poly_mul_schb_param.md
POLY_MUL_SCHB_PARAM -- requirements
Module: poly_mul_schb_param

Interface
REQ-001 SHALL have parameter N, default 256: number of polynomial coefficients; power of two, 4..512.
REQ-002 SHALL have parameter COEFF_WIDTH, default 16: width of result and public coefficients.
REQ-003 SHALL have parameter DATA_W, default 16: memory word width; COEFF_WIDTH <= DATA_W.
REQ-004 SHALL have parameter S_BITS, default 2: secret coefficient width, 2..5; N*S_BITS SHALL be a multiple of DATA_W.
REQ-005 SHALL have parameter ADDR_W, default 10: memory address width.
REQ-006 SHALL have parameters A_BASE (default 0), S_BASE (default 256) and R_BASE (default 512): base addresses of the public, secret and result regions.
REQ-007 clk  input  1  clock; all logic is rising-edge.
REQ-008 resetn  input  1  synchronous, active-low reset.
REQ-009 start  input  1  request a multiply; sampled only in IDLE.
REQ-010 acc  input  1  sampled with start; 1 = add the product into the existing result, 0 = overwrite the result.
REQ-011 negacyc  input  1  sampled with start; 1 = reduce mod x^N+1, 0 = reduce mod x^N-1.
REQ-012 wb  input  1  request write-back of the result; sampled only in IDLE.
REQ-013 data_in  input  DATA_W  memory read data; 1-cycle read latency.
REQ-014 r_addr  output  ADDR_W  memory read address.
REQ-015 w_addr  output  ADDR_W  memory write address.
REQ-016 write  output  1  memory write enable.
REQ-017 data_out  output  DATA_W  write data; result zero-extended to DATA_W.
REQ-018 busy  output  1  high whenever the state is not IDLE.
REQ-019 done  output  1  one-cycle completion pulse.

Function
REQ-020 States SHALL be IDLE, LOAD_S, COMPUTE and WRITE_BACK.
REQ-021 Transitions:
- IDLE->LOAD_S on start.
- IDLE->WRITE_BACK on wb with start low; start wins when both are high.
- LOAD_S->COMPUTE after S_WORDS = N*S_BITS/DATA_W reads plus 1 drain cycle.
- COMPUTE->IDLE after N reads plus 2 drain cycles.
- WRITE_BACK->IDLE after N writes.
REQ-022 Secret coefficient s_k SHALL be the bits [S_BITS*(k mod (DATA_W/S_BITS)) +: S_BITS] of word S_BASE + k/(DATA_W/S_BITS), in sign-magnitude form:
- the MSB is the sign;
- the lower S_BITS-1 bits are the magnitude;
- a sign of 1 with a magnitude of 0 SHALL equal 0.
REQ-023 Public coefficient a_j SHALL be data_in[COEFF_WIDTH-1:0] read from A_BASE + j, for j = 0..N-1 in ascending order.
REQ-024 On start with acc=0, all result lanes SHALL clear before the first accumulation; with acc=1, the lanes SHALL be retained.
REQ-025 After COMPUTE, res_i SHALL equal (acc ? old res_i : 0) + sum over j of a_j * s_((i-j) mod N) * sgn, modulo 2^COEFF_WIDTH.
- sgn = -1 when i < j and negacyc = 1.
- sgn = +1 otherwise.
REQ-026 The secret SHALL rotate one position per COMPUTE step; in negacyclic mode, the sign SHALL invert on wrap.
REQ-027 Latency: with start sampled at edge T, done SHALL be high in cycle T + S_WORDS + N + 3.
- With defaults, S_WORDS = 32, so done is high in cycle T + 291.
- busy SHALL be high from T+1 through the done cycle.
REQ-028 In WRITE_BACK, write SHALL be high for exactly N consecutive cycles, starting in the cycle after wb is sampled.
- w_addr = R_BASE + i and data_out = res_i, for i = 0..N-1.
- done SHALL pulse with the last write.
- res SHALL be unchanged afterwards (rotating readout).
REQ-029 r_addr SHALL be 0 outside LOAD_S/COMPUTE read cycles; w_addr SHALL be 0 when write is low.
REQ-030 start and wb SHALL be ignored while busy; acc and negacyc SHALL be ignored outside the start cycle.
REQ-031 write SHALL never be high in LOAD_S or COMPUTE.

Reset
REQ-032 resetn=0 at any clock edge SHALL force IDLE and clear all result lanes, the secret register and all counters.
REQ-033 After reset, SHALL drive busy=0, done=0, write=0, r_addr=0, w_addr=0 and data_out=0, including when reset lands mid-COMPUTE or mid-WRITE_BACK; no write occurs afterwards.
REQ-034 The first start after reset with acc=1 SHALL accumulate onto zero.

Verification
REQ-035 Verification SHALL cover:
- N=256, negacyc=1, acc=0, a=x (a_1=1), s_255=+1 -> res_0 = 0xFFFF (-1); all other lanes 0; done at T+291.
- Same stimulus with negacyc=0 -> res_0 = 0x0001; all other lanes 0.
- S_BITS=4, a_0=3, s_0 = -5 (0xD) -> res_0 = 0xFFF1; then start with acc=1 and the same inputs -> res_0 = 0xFFE2.
- s_0 = negative zero (0x2 at S_BITS=2), a=all 0xFFFF -> all lanes 0.
- wb after compute -> exactly 256 writes to 512..767 in order; a second wb returns identical data.
- resetn pulsed at COMPUTE step 100, then wb -> all 256 writes are 0, and busy, done and write stay low during reset.
- start and wb high in the same IDLE cycle -> a multiply runs and no write occurs.
- start pulses while busy -> no change in the done cycle or in the result.
